// File: rtl/dct8_chen_flex.sv
// 8-point forward 1-D DCT row stage (Chen even/odd split, orthonormal scaling).
// 22 constant products share NUM_MUL multipliers; a one-row input buffer hides the compute time.
module dct8_chen_flex #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 16,
  parameter int FRAC    = 15,
  parameter int CONST_W = 16,
  parameter int NUM_MUL = 4,
  parameter int ROUND   = 1,
  parameter int SAT     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*IN_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*OUT_W-1:0]   out_data,
  output logic                 out_sat
);

  localparam int NP  = 22;
  localparam int NB  = (NP + NUM_MUL - 1) / NUM_MUL;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int OPW = IN_W + 3;
  localparam int PW  = OPW + CONST_W;
  localparam int AW  = IN_W + CONST_W + 4;
  localparam logic signed [AW-1:0] RND_C = (ROUND != 0) ? (AW'(32'sd1) <<< (FRAC - 1)) : '0;
  localparam logic signed [AW-1:0] OMAX  = (AW'(32'sd1) <<< (OUT_W - 1)) - AW'(32'sd1);
  localparam logic signed [AW-1:0] OMIN  = -OMAX - AW'(32'sd1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_FIN = 2'd2} state_t;

  // Ck rescaled from the 2^15 table with round-to-nearest when FRAC < 15.
  function automatic logic signed [CONST_W-1:0] cval(input logic [2:0] k);
    int v;
    int sh;
    case (k)
      3'd1:    v = 32'sd16069;
      3'd2:    v = 32'sd15137;
      3'd3:    v = 32'sd13623;
      3'd4:    v = 32'sd11585;
      3'd5:    v = 32'sd9102;
      3'd6:    v = 32'sd6270;
      3'd7:    v = 32'sd3196;
      default: v = 32'sd0;
    endcase
    sh = 32'sd15 - FRAC;
    if (sh > 32'sd0) v = (v + (32'sd1 <<< (sh - 32'sd1))) >>> sh;
    return CONST_W'(v);
  endfunction

  function automatic logic signed [CONST_W-1:0] coef(input logic [5:0] idx);
    case (idx)
      6'd0, 6'd1:   coef = cval(3'd4);
      6'd2:         coef = cval(3'd2);
      6'd3, 6'd4:   coef = cval(3'd6);
      6'd5:         coef = -cval(3'd2);
      6'd6:         coef = cval(3'd1);
      6'd7:         coef = cval(3'd3);
      6'd8:         coef = cval(3'd5);
      6'd9:         coef = cval(3'd7);
      6'd10:        coef = cval(3'd3);
      6'd11:        coef = -cval(3'd7);
      6'd12:        coef = -cval(3'd1);
      6'd13:        coef = -cval(3'd5);
      6'd14:        coef = cval(3'd5);
      6'd15:        coef = -cval(3'd1);
      6'd16:        coef = cval(3'd7);
      6'd17:        coef = cval(3'd3);
      6'd18:        coef = cval(3'd7);
      6'd19:        coef = -cval(3'd5);
      6'd20:        coef = cval(3'd3);
      6'd21:        coef = -cval(3'd1);
      default:      coef = '0;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic                    take_row, do_beat, do_write;
  logic                    buf_full_q, buf_full_d;
  logic [8*IN_W-1:0]       buf_q, buf_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic signed [OPW-1:0]   xv [8];
  logic signed [OPW-1:0]   sv [4];
  logic signed [OPW-1:0]   bf_d [4];
  logic signed [OPW-1:0]   bf_sum, bf_dif, bf_e2, bf_e3;
  logic signed [OPW-1:0]   sum_q, dif_q, e2_q, e3_q;
  logic signed [OPW-1:0]   dv_q [4];
  logic signed [AW-1:0]    acc_q [8];
  logic signed [AW-1:0]    acc_d [8];
  logic signed [AW-1:0]    acc_sum [8];
  logic [5:0]              idx;
  logic [3:0]              rel;
  logic [2:0]              dst;
  logic signed [OPW-1:0]   op;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    rnd, shf;
  logic [8*OUT_W-1:0]      res_pack;
  logic                    sat_any;
  logic                    out_valid_q, out_valid_d;
  logic [8*OUT_W-1:0]      out_data_q, out_data_d;
  logic                    out_sat_q, out_sat_d;

  assign in_ready  = !buf_full_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (buf_full_q) state_d = S_MUL; else state_d = S_IDLE;
      S_MUL:   if (beat_q == BW'(NB - 1)) state_d = S_FIN; else state_d = S_MUL;
      S_FIN:   if (!out_valid_q || out_ready) state_d = S_IDLE; else state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    take_row = 1'b0;
    do_beat  = 1'b0;
    do_write = 1'b0;
    case (state_q)
      S_IDLE:  take_row = buf_full_q;
      S_MUL:   do_beat  = 1'b1;
      S_FIN:   do_write = !out_valid_q || out_ready;
      default: take_row = 1'b0;
    endcase
  end

  // Input buffer next state and butterflies of the buffered row.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    if (take_row) begin
      buf_full_d = 1'b0;
    end else if (in_valid && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_d      = in_data;
    end else begin
      buf_full_d = buf_full_q;
    end
    for (int n = 0; n < 8; n++) xv[n] = OPW'($signed(buf_q[n*IN_W +: IN_W]));
    for (int n = 0; n < 4; n++) begin
      sv[n]   = xv[n] + xv[7-n];
      bf_d[n] = xv[n] - xv[7-n];
    end
    bf_sum = sv[0] + sv[1] + sv[2] + sv[3];
    bf_dif = sv[0] - sv[1] - sv[2] + sv[3];
    bf_e2  = sv[0] - sv[3];
    bf_e3  = sv[1] - sv[2];
  end

  // One multiply beat: each shared multiplier picks its product index, operand and target accumulator.
  always_comb begin
    idx  = '0;
    rel  = '0;
    dst  = '0;
    op   = '0;
    prod = '0;
    for (int k = 0; k < 8; k++) acc_sum[k] = acc_q[k];
    for (int m = 0; m < NUM_MUL; m++) begin
      idx = 6'(int'(beat_q) * NUM_MUL + m);
      rel = 4'(idx - 6'd6);
      case (idx)
        6'd0:    begin op = sum_q; dst = 3'd0; end
        6'd1:    begin op = dif_q; dst = 3'd4; end
        6'd2:    begin op = e2_q;  dst = 3'd2; end
        6'd3:    begin op = e3_q;  dst = 3'd2; end
        6'd4:    begin op = e2_q;  dst = 3'd6; end
        6'd5:    begin op = e3_q;  dst = 3'd6; end
        default: begin
          op  = (idx < 6'd22) ? dv_q[rel[1:0]] : '0;
          dst = {rel[3:2], 1'b1};
        end
      endcase
      prod = op * coef(idx);
      acc_sum[dst] = acc_sum[dst] + {{(AW-PW){prod[PW-1]}}, prod};
    end
  end

  // Accumulator and beat counter next state.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      if (take_row)     acc_d[k] = '0;
      else if (do_beat) acc_d[k] = acc_sum[k];
      else              acc_d[k] = acc_q[k];
    end
    if (take_row)     beat_d = '0;
    else if (do_beat) beat_d = beat_q + BW'(1);
    else              beat_d = beat_q;
  end

  // Round, shift, saturate/wrap, and output register next state.
  always_comb begin
    rnd         = '0;
    shf         = '0;
    res_pack    = '0;
    sat_any     = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    for (int k = 0; k < 8; k++) begin
      rnd = acc_q[k] + RND_C;
      shf = rnd >>> FRAC;
      if (SAT != 0 && shf > OMAX) begin
        res_pack[k*OUT_W +: OUT_W] = OMAX[OUT_W-1:0];
        sat_any = 1'b1;
      end else if (SAT != 0 && shf < OMIN) begin
        res_pack[k*OUT_W +: OUT_W] = OMIN[OUT_W-1:0];
        sat_any = 1'b1;
      end else begin
        res_pack[k*OUT_W +: OUT_W] = shf[OUT_W-1:0];
      end
    end
    if (do_write) begin
      out_valid_d = 1'b1;
      out_data_d  = res_pack;
      out_sat_d   = sat_any;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_full_q  <= 1'b0;
      buf_q       <= '0;
      beat_q      <= '0;
      sum_q       <= '0;
      dif_q       <= '0;
      e2_q        <= '0;
      e3_q        <= '0;
      for (int n = 0; n < 4; n++) dv_q[n] <= '0;
      for (int k = 0; k < 8; k++) acc_q[k] <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      buf_full_q  <= buf_full_d;
      buf_q       <= buf_d;
      beat_q      <= beat_d;
      if (take_row) begin
        sum_q <= bf_sum;
        dif_q <= bf_dif;
        e2_q  <= bf_e2;
        e3_q  <= bf_e3;
        for (int n = 0; n < 4; n++) dv_q[n] <= bf_d[n];
      end
      for (int k = 0; k < 8; k++) acc_q[k] <= acc_d[k];
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_dct8_chen_flex.sv
// Directed bench for dct8_chen_flex: three builds (default, floor/NUM_MUL=1, 8-bit saturating/NUM_MUL=22)
// driven with hand-computed rows, plus latency, backpressure and mid-row reset scenarios.
module tb_dct8_chen_flex;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         iv_a, iv_b, iv_c, ir_a, ir_b, ir_c;
  logic         ov_a, ov_b, ov_c, or_a, or_b, or_c, os_a, os_b, os_c;
  logic [127:0] in_data, od_a, od_b;
  logic [63:0]  od_c;

  int checks   = 0;
  int failures = 0;
  int ea[8], eb[8], ec[8];
  int sa, sb, sc;

  dct8_chen_flex dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .in_data(in_data),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .out_sat(os_a));

  dct8_chen_flex #(.NUM_MUL(1), .ROUND(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .in_data(in_data),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .out_sat(os_b));

  dct8_chen_flex #(.NUM_MUL(22), .OUT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .in_data(in_data),
    .out_valid(ov_c), .out_ready(or_c), .out_data(od_c), .out_sat(os_c));

  task automatic check_val(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] get_a(input int k);
    logic signed [15:0] v;
    v = od_a[k*16 +: 16];
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] get_b(input int k);
    logic signed [15:0] v;
    v = od_b[k*16 +: 16];
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] get_c(input int k);
    logic signed [7:0] v;
    v = od_c[k*8 +: 8];
    return 32'(v);
  endfunction

  function automatic logic [127:0] pack8(input int v[8]);
    logic [127:0] p;
    for (int n = 0; n < 8; n++) p[n*16 +: 16] = 16'(v[n]);
    return p;
  endfunction

  // Offer one row to all three builds, check latency of the default build, then check and drain all outputs.
  task automatic run_vec(input string tag, input logic [127:0] din);
    int cnt;
    in_data = din;
    iv_a = 1'b1; iv_b = 1'b1; iv_c = 1'b1;
    check_val({tag, "_ready"}, 32'(ir_a & ir_b & ir_c), 32'sd1);
    @(posedge clk); #1;
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    cnt = 0;
    while (!ov_a && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_val({tag, "_latency"}, cnt, 32'sd8);
    cnt = 0;
    while (!(ov_b && ov_c) && cnt < 60) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_val({tag, "_valid_bc"}, 32'(ov_b & ov_c), 32'sd1);
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("%s_a_X%0d", tag, k), get_a(k), ea[k]);
      check_val($sformatf("%s_b_X%0d", tag, k), get_b(k), eb[k]);
      check_val($sformatf("%s_c_X%0d", tag, k), get_c(k), ec[k]);
    end
    check_val({tag, "_a_sat"}, 32'(os_a), sa);
    check_val({tag, "_b_sat"}, 32'(os_b), sb);
    check_val({tag, "_c_sat"}, 32'(os_c), sc);
    or_a = 1'b1; or_b = 1'b1; or_c = 1'b1;
    @(posedge clk); #1;
    or_a = 1'b0; or_b = 1'b0; or_c = 1'b0;
    check_val({tag, "_drained"}, 32'(ov_a | ov_b | ov_c), 32'sd0);
  endtask

  // Offer one row to the default build only, waiting a bounded time for in_ready.
  task automatic offer_a(input logic [127:0] din, output bit acc);
    in_data = din;
    iv_a    = 1'b1;
    acc     = 1'b0;
    for (int t = 0; t < 30; t++) begin
      if (ir_a) begin
        @(posedge clk); #1;
        acc = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    iv_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int v[8];
    bit acc[4];
    int rec0[3];
    int rsat[3];
    int got_n;
    int extra;

    rst_n = 1'b0;
    iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    or_a = 1'b0; or_b = 1'b0; or_c = 1'b0;
    in_data = '0;
    rec0 = '{0, 0, 0};
    rsat = '{0, 0, 0};
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", 32'(ir_a & ir_b & ir_c), 32'sd1);
    check_val("rst_out_valid", 32'(ov_a | ov_b | ov_c), 32'sd0);
    check_val("rst_out_data", 32'(od_a == 128'd0), 32'sd1);
    check_val("rst_out_sat", 32'(os_a), 32'sd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    v  = '{100, 100, 100, 100, 100, 100, 100, 100};
    ea = '{283, 0, 0, 0, 0, 0, 0, 0};
    eb = '{282, 0, 0, 0, 0, 0, 0, 0};
    ec = '{127, 0, 0, 0, 0, 0, 0, 0};
    sa = 0; sb = 0; sc = 1;
    run_vec("dc100", pack8(v));

    v  = '{1000, 0, 0, 0, 0, 0, 0, 0};
    ea = '{354, 490, 462, 416, 354, 278, 191, 98};
    eb = '{353, 490, 461, 415, 353, 277, 191, 97};
    ec = '{127, 127, 127, 127, 127, 127, 127, 98};
    sa = 0; sb = 0; sc = 1;
    run_vec("imp_pos", pack8(v));

    v  = '{-1000, 0, 0, 0, 0, 0, 0, 0};
    ea = '{-354, -490, -462, -416, -354, -278, -191, -98};
    eb = '{-354, -491, -462, -416, -354, -278, -192, -98};
    ec = '{-128, -128, -128, -128, -128, -128, -128, -98};
    sa = 0; sb = 0; sc = 1;
    run_vec("imp_neg", pack8(v));

    v  = '{100, -100, 100, -100, 100, -100, 100, -100};
    ea = '{0, 51, 0, 60, 0, 90, 0, 256};
    eb = '{0, 50, 0, 60, 0, 89, 0, 256};
    ec = '{0, 51, 0, 60, 0, 90, 0, 127};
    sa = 0; sb = 0; sc = 1;
    run_vec("alt", pack8(v));

    v  = '{0, 1000, 0, 0, 0, 0, 0, 0};
    ea = '{354, 416, 191, -98, -354, -490, -462, -278};
    eb = '{353, 415, 191, -98, -354, -491, -462, -278};
    ec = '{127, 127, 127, -98, -128, -128, -128, -128};
    sa = 0; sb = 0; sc = 1;
    run_vec("imp_x1", pack8(v));

    // Backpressure: rows with X0 = 283, 566, -283; the fourth row must be refused.
    or_a = 1'b0;
    v = '{100, 100, 100, 100, 100, 100, 100, 100};
    offer_a(pack8(v), acc[0]);
    v = '{200, 200, 200, 200, 200, 200, 200, 200};
    offer_a(pack8(v), acc[1]);
    v = '{-100, -100, -100, -100, -100, -100, -100, -100};
    offer_a(pack8(v), acc[2]);
    v = '{300, 300, 300, 300, 300, 300, 300, 300};
    offer_a(pack8(v), acc[3]);
    check_val("bp_acc0", 32'(acc[0]), 32'sd1);
    check_val("bp_acc1", 32'(acc[1]), 32'sd1);
    check_val("bp_acc2", 32'(acc[2]), 32'sd1);
    check_val("bp_acc3", 32'(acc[3]), 32'sd0);
    check_val("bp_in_ready", 32'(ir_a), 32'sd0);
    check_val("bp_holding", 32'(ov_a), 32'sd1);
    check_val("bp_hold_X0", get_a(0), 32'sd283);

    got_n = 0;
    or_a  = 1'b1;
    for (int t = 0; t < 100 && got_n < 3; t++) begin
      if (ov_a) begin
        rec0[got_n] = get_a(0);
        rsat[got_n] = int'(os_a);
        got_n++;
      end
      @(posedge clk); #1;
    end
    or_a = 1'b0;
    check_val("bp_count", got_n, 32'sd3);
    check_val("bp_row1_X0", rec0[0], 32'sd283);
    check_val("bp_row2_X0", rec0[1], 32'sd566);
    check_val("bp_row3_X0", rec0[2], -32'sd283);
    check_val("bp_row_sat", rsat[0] + rsat[1] + rsat[2], 32'sd0);
    extra = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov_a) extra++;
    end
    check_val("bp_no_dup", extra, 32'sd0);
    check_val("bp_ready_after", 32'(ir_a), 32'sd1);

    // Reset while the default build is in its multiply beats.
    v = '{1000, 0, 0, 0, 0, 0, 0, 0};
    offer_a(pack8(v), acc[0]);
    check_val("mr_accept", 32'(acc[0]), 32'sd1);
    repeat (3) @(posedge clk);
    #1;
    v = '{7, 7, 7, 7, 7, 7, 7, 7};
    in_data = pack8(v);
    iv_a  = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("mr_out_valid", 32'(ov_a), 32'sd0);
    check_val("mr_in_ready", 32'(ir_a), 32'sd1);
    check_val("mr_out_data", 32'(od_a == 128'd0), 32'sd1);
    rst_n = 1'b1;
    iv_a  = 1'b0;
    extra = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (ov_a) extra++;
    end
    check_val("mr_discarded", extra, 32'sd0);

    v  = '{1000, 0, 0, 0, 0, 0, 0, 0};
    ea = '{354, 490, 462, 416, 354, 278, 191, 98};
    eb = '{353, 490, 461, 415, 353, 277, 191, 97};
    ec = '{127, 127, 127, 127, 127, 127, 127, 98};
    sa = 0; sb = 0; sc = 1;
    run_vec("post_rst", pack8(v));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
